// File: rtl/pe_stream_pkg.sv
// Shared sizing helpers, channel index type and default channel IDs
// for the PE stream buffer bank.
package pe_stream_pkg;

  // Bits needed to hold a fill count of 0..depth inclusive.
  function automatic int calc_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Address bits plus one wrap bit, so full and empty can be told apart.
  function automatic int calc_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CH_IDX_W = 8;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  typedef enum logic [CH_IDX_W-1:0] {
    CH_IFMAP = 8'd0,
    CH_FLTR  = 8'd1,
    CH_IPSUM = 8'd2,
    CH_OPSUM = 8'd3
  } ch_id_e;

endpackage

// File: rtl/pe_stream_buffer_bank_if.sv
// Flattened per-channel valid/ready streams between the memory side and the PE array.
// master = producer/consumer side, slave = the buffer bank.
interface pe_stream_buffer_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
);
  logic [NUM_CH-1:0]            wr_valid;
  logic [NUM_CH-1:0]            wr_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
  logic [NUM_CH-1:0]            rd_valid;
  logic [NUM_CH-1:0]            rd_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid,
    output wr_data,
    output rd_ready,
    input  wr_ready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_ready,
    output wr_ready,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/pe_stream_chan_fifo.sv
// One buffer channel: register-array FIFO with wrap-bit pointers, fill level,
// pre-fill read gate and synchronous flush.
module pe_stream_chan_fifo
  import pe_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int AUTO_REARM = 1,
  localparam int LVL_W     = calc_lvl_w(FIFO_DEPTH),
  localparam int PTR_W     = calc_ptr_w(FIFO_DEPTH)
) (
  input  logic                  pe_clk,
  input  logic                  rst,
  input  logic [LVL_W-1:0]      prefill_lvl,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0]      level,
  output logic                  prefill_done
);

  localparam int               AW        = PTR_W - 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             gate_reg, gate_next;
  logic [LVL_W-1:0] thresh;
  logic             full, empty, push, pop;

  always_comb begin
    full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
               (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    empty    = (wr_ptr_reg == rd_ptr_reg);
    wr_ready = !full;
    rd_valid = !empty && gate_reg;
    push     = wr_valid && wr_ready;
    pop      = rd_valid && rd_ready;
    thresh   = (prefill_lvl > DEPTH_LVL) ? DEPTH_LVL : prefill_lvl;
  end

  // Head word is masked while empty so an idle channel presents zero.
  assign rd_data      = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign level        = level_reg;
  assign prefill_done = gate_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    gate_next   = gate_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
      gate_next   = 1'b0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_next = level_reg + LVL_W'(1);
        2'b01:   level_next = level_reg - LVL_W'(1);
        default: level_next = level_reg;
      endcase
      // A raised threshold never closes an open gate; only draining empty does.
      if ((AUTO_REARM != 0) && (thresh != '0) && pop && !push &&
          (level_reg == LVL_W'(1))) begin
        gate_next = 1'b0;
      end else if (level_next >= thresh) begin
        gate_next = 1'b1;
      end
    end
  end

  always_ff @(posedge pe_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      gate_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      gate_reg   <= gate_next;
    end
  end

  // Storage carries no reset; pointers alone decide what is readable.
  always_ff @(posedge pe_clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/pe_stream_buffer_bank.sv
// NUM_CH independent stream FIFOs between the PE memory interface and the PE array.
// Optional sticky overflow/underflow flags: define PE_STREAM_BUFFER_BANK_ERR_EN.
module pe_stream_buffer_bank
  import pe_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int AUTO_REARM = 1,
  localparam int LVL_W     = calc_lvl_w(FIFO_DEPTH)
) (
  input  logic                    pe_clk,
  input  logic                    rst,
  input  logic [NUM_CH*LVL_W-1:0] prefill_lvl,
  input  logic [NUM_CH-1:0]       flush,
  pe_stream_buffer_bank_if.slave  bus,
`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
  output logic [NUM_CH-1:0]       err_ovf,
  output logic [NUM_CH-1:0]       err_udf,
  input  logic                    err_clr,
`endif
  output logic [NUM_CH*LVL_W-1:0] level,
  output logic [NUM_CH-1:0]       prefill_done
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic                  chan_wr_ready;
    logic                  chan_rd_valid;
    logic                  chan_done;
    logic [DATA_WIDTH-1:0] chan_rd_data;
    logic [LVL_W-1:0]      chan_level;

    pe_stream_chan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AUTO_REARM (AUTO_REARM)
    ) u_fifo (
      .pe_clk       (pe_clk),
      .rst          (rst),
      .prefill_lvl  (prefill_lvl[gi*LVL_W +: LVL_W]),
      .flush        (flush[gi]),
      .wr_valid     (bus.wr_valid[gi]),
      .wr_ready     (chan_wr_ready),
      .wr_data      (bus.wr_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid     (chan_rd_valid),
      .rd_ready     (bus.rd_ready[gi]),
      .rd_data      (chan_rd_data),
      .level        (chan_level),
      .prefill_done (chan_done)
    );

    assign bus.wr_ready[gi]                          = chan_wr_ready;
    assign bus.rd_valid[gi]                          = chan_rd_valid;
    assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH]  = chan_rd_data;
    assign level[gi*LVL_W +: LVL_W]                  = chan_level;
    assign prefill_done[gi]                          = chan_done;

`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
    logic ovf_reg, udf_reg;
    logic ovf_set, udf_set;

    // Underflow only counts once the gate is open; polling a gated channel is normal.
    assign ovf_set = bus.wr_valid[gi] && !chan_wr_ready;
    assign udf_set = bus.rd_ready[gi] && !chan_rd_valid && chan_done;

    always_ff @(posedge pe_clk or posedge rst) begin
      if (rst) begin
        ovf_reg <= 1'b0;
        udf_reg <= 1'b0;
      end else begin
        if (ovf_set)      ovf_reg <= 1'b1;
        else if (err_clr) ovf_reg <= 1'b0;
        if (udf_set)      udf_reg <= 1'b1;
        else if (err_clr) udf_reg <= 1'b0;
      end
    end

    assign err_ovf[gi] = ovf_reg;
    assign err_udf[gi] = udf_reg;
`endif
  end

endmodule

// File: tb/tb_pe_stream_buffer_bank.sv
// Directed bench for pe_stream_buffer_bank: reset, gating, full, wrap, flush, clamp, async reset.
// Also exercises the error flags when PE_STREAM_BUFFER_BANK_ERR_EN is defined.
module tb_pe_stream_buffer_bank;
  import pe_stream_pkg::*;

  localparam int DW    = 16;
  localparam int NC    = 4;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic              pe_clk = 1'b0;
  logic              rst    = 1'b0;
  logic [NC*LW-1:0]  prefill_lvl;
  logic [NC-1:0]     flush;
  logic [NC*LW-1:0]  level;
  logic [NC-1:0]     prefill_done;
`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
  logic [NC-1:0]     err_ovf;
  logic [NC-1:0]     err_udf;
  logic              err_clr;
`endif

  pe_stream_buffer_bank_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

  pe_stream_buffer_bank #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NC),
    .FIFO_DEPTH (DEPTH),
    .AUTO_REARM (1)
  ) dut (
    .pe_clk       (pe_clk),
    .rst          (rst),
    .prefill_lvl  (prefill_lvl),
    .flush        (flush),
    .bus          (bus.slave),
`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
    .err_ovf      (err_ovf),
    .err_udf      (err_udf),
    .err_clr      (err_clr),
`endif
    .level        (level),
    .prefill_done (prefill_done)
  );

  always #5 pe_clk = ~pe_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [LW-1:0] lvl(input int ch);
    return level[ch*LW +: LW];
  endfunction

  function automatic logic [DW-1:0] rdat(input int ch);
    return bus.rd_data[ch*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge pe_clk);
    #1;
  endtask

  task automatic set_wr(input int ch, input logic v, input logic [DW-1:0] d);
    bus.wr_valid[ch]        = v;
    bus.wr_data[ch*DW +: DW] = d;
  endtask

  task automatic push_word(input int ch, input logic [DW-1:0] d);
    set_wr(ch, 1'b1, d);
    tick();
    bus.wr_valid[ch] = 1'b0;
  endtask

  initial begin
    bus.wr_valid = '0;
    bus.wr_data  = '0;
    bus.rd_ready = '0;
    flush        = '0;
    prefill_lvl  = '0;
    prefill_lvl[CH_IFMAP*LW +: LW] = 5'd4;
`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
    err_clr = 1'b0;
`endif

    // Reset asserted
    #1 rst = 1'b1;
    #2;
    check("rst_wr_ready", {28'd0, bus.wr_ready}, 32'hF);
    check("rst_rd_valid", {28'd0, bus.rd_valid}, 32'h0);
    check("rst_level",    {12'd0, level},        32'h0);
    check("rst_rd_data",  bus.rd_data[31:0],     32'h0);
    @(negedge pe_clk);
    rst = 1'b0;
    tick();
    check("rel_wr_ready", {28'd0, bus.wr_ready},   32'hF);
    check("rel_rd_valid", {28'd0, bus.rd_valid},   32'h0);
    check("rel_level",    {12'd0, level},          32'h0);
    check("rel_done",     {28'd0, prefill_done},   32'hE);

    // Pre-fill gating on ch0 (threshold 4)
    for (int k = 0; k < 3; k++) push_word(0, 16'hA000 + 16'(k));
    check("pf_valid_3", {31'd0, bus.rd_valid[0]}, 32'd0);
    check("pf_level_3", {27'd0, lvl(0)},          32'd3);
    push_word(0, 16'hA003);
    check("pf_valid_4", {31'd0, bus.rd_valid[0]}, 32'd1);
    check("pf_level_4", {27'd0, lvl(0)},          32'd4);
    bus.rd_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pf_rd%0d", k), {16'd0, rdat(0)}, 32'hA000 + k);
      tick();
    end
    bus.rd_ready[0] = 1'b0;
    check("pf_drain_level", {27'd0, lvl(0)},          32'd0);
    check("pf_rearm_done",  {31'd0, prefill_done[0]}, 32'd0);
    check("pf_drain_valid", {31'd0, bus.rd_valid[0]}, 32'd0);

    // Full boundary on ch1
    for (int k = 0; k < DEPTH; k++) push_word(1, 16'hB000 + 16'(k));
    check("full_wr_ready", {31'd0, bus.wr_ready[1]}, 32'd0);
    check("full_level",    {27'd0, lvl(1)},          32'd16);
    set_wr(1, 1'b1, 16'hBEEF);
    tick();
    check("full_held_level", {27'd0, lvl(1)}, 32'd16);
    bus.rd_ready[1] = 1'b1;
    check("full_head", {16'd0, rdat(1)}, 32'hB000);
    tick();
    bus.rd_ready[1] = 1'b0;
    check("full_pop_level",  {27'd0, lvl(1)},          32'd15);
    check("full_pop_ready",  {31'd0, bus.wr_ready[1]}, 32'd1);
    check("full_next_head",  {16'd0, rdat(1)},         32'hB001);
    tick();
    bus.wr_valid[1] = 1'b0;
    check("full_refill_level", {27'd0, lvl(1)}, 32'd16);
`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
    check("err_ovf_full", {28'd0, err_ovf}, 32'h2);
    check("err_udf_none", {28'd0, err_udf}, 32'h0);
`endif

    // Streaming wrap-around on ch2
    push_word(2, 16'h0000);
    check("wrap_latency_valid", {31'd0, bus.rd_valid[2]}, 32'd1);
    bus.rd_ready[2] = 1'b1;
    for (int k = 1; k < 40; k++) begin
      set_wr(2, 1'b1, 16'(k));
      check($sformatf("wrap_rd%0d", k - 1), {16'd0, rdat(2)}, 32'(k - 1));
      tick();
      check($sformatf("wrap_lvl%0d", k), {27'd0, lvl(2)}, 32'd1);
    end
    bus.wr_valid[2] = 1'b0;
    check("wrap_rd39", {16'd0, rdat(2)}, 32'h27);
    tick();
    bus.rd_ready[2] = 1'b0;
    check("wrap_end_level", {27'd0, lvl(2)},          32'd0);
    check("wrap_end_valid", {31'd0, bus.rd_valid[2]}, 32'd0);

    // Flush mid-stream on ch3 while ch0 and ch2 push
    push_word(0, 16'hC000);
    push_word(0, 16'hC001);
    for (int k = 0; k < 7; k++) push_word(3, 16'hD000 + 16'(k));
    check("fl_pre_level", {27'd0, lvl(3)},          32'd7);
    check("fl_pre_done",  {31'd0, prefill_done[3]}, 32'd1);
    flush[3] = 1'b1;
    bus.rd_ready[3] = 1'b1;
    set_wr(3, 1'b1, 16'hDEAD);
    set_wr(0, 1'b1, 16'hC002);
    set_wr(2, 1'b1, 16'hE000);
    tick();
    flush[3] = 1'b0;
    bus.rd_ready[3] = 1'b0;
    bus.wr_valid = '0;
    check("fl_level3",   {27'd0, lvl(3)},          32'd0);
    check("fl_done3",    {31'd0, prefill_done[3]}, 32'd0);
    check("fl_valid3",   {31'd0, bus.rd_valid[3]}, 32'd0);
    check("fl_ready3",   {31'd0, bus.wr_ready[3]}, 32'd1);
    check("fl_rd_data3", {16'd0, rdat(3)},         32'h0);
    check("fl_level0",   {27'd0, lvl(0)},          32'd3);
    check("fl_level1",   {27'd0, lvl(1)},          32'd16);
    check("fl_level2",   {27'd0, lvl(2)},          32'd1);
    tick();
    check("fl_reopen3",  {31'd0, prefill_done[3]}, 32'd1);
`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
    check("fl_err_udf",  {28'd0, err_udf}, 32'h0);
`endif

    // Threshold above depth clamps to depth; raising it keeps an open gate open
    prefill_lvl[3*LW +: LW] = 5'd31;
    tick();
    check("clamp_keep_open", {31'd0, prefill_done[3]}, 32'd1);
    flush[3] = 1'b1;
    tick();
    flush[3] = 1'b0;
    check("clamp_flushed", {31'd0, prefill_done[3]}, 32'd0);
    for (int k = 0; k < DEPTH - 1; k++) push_word(3, 16'hF000 + 16'(k));
    check("clamp_15_valid", {31'd0, bus.rd_valid[3]}, 32'd0);
    push_word(3, 16'hF00F);
    check("clamp_16_valid", {31'd0, bus.rd_valid[3]}, 32'd1);
    check("clamp_16_level", {27'd0, lvl(3)},          32'd16);

`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
    // Sticky flags: clear, set-over-clear, gated polling, real underflow
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr_ovf", {28'd0, err_ovf}, 32'h0);
    bus.wr_valid[1] = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    bus.wr_valid[1] = 1'b0;
    check("err_set_wins", {28'd0, err_ovf}, 32'h2);
    bus.rd_ready[0] = 1'b1;
    tick();
    bus.rd_ready[0] = 1'b0;
    check("err_gated_poll", {28'd0, err_udf}, 32'h0);
    bus.rd_ready[2] = 1'b1;
    tick();
    tick();
    bus.rd_ready[2] = 1'b0;
    check("err_udf_ch2", {28'd0, err_udf}, 32'h4);
`endif

    // Asynchronous reset in the middle of streaming
    bus.rd_ready[2] = 1'b1;
    set_wr(2, 1'b1, 16'h1234);
    @(negedge pe_clk);
    #2 rst = 1'b1;
    #1;
    check("arst_level",    {12'd0, level},        32'h0);
    check("arst_wr_ready", {28'd0, bus.wr_ready}, 32'hF);
    check("arst_rd_valid", {28'd0, bus.rd_valid}, 32'h0);
    check("arst_done",     {28'd0, prefill_done}, 32'h0);
`ifdef PE_STREAM_BUFFER_BANK_ERR_EN
    check("arst_err", {24'd0, err_ovf, err_udf}, 32'h0);
`endif
    tick();
    check("arst_wr_ignored", {27'd0, lvl(2)}, 32'd0);
    bus.wr_valid = '0;
    bus.rd_ready = '0;
    @(negedge pe_clk);
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
